demux32_4_router: RTL

- 1-to-4 router for 32-bit data: the distribution counterpart of the 4-input result selector.
- Accepts one word per handshake on a single input channel and steers it to the output channel chosen by a 2-bit select.
- Each output channel has its own small FIFO with valid/ready, so one stalled consumer does not block traffic bound for the others.
- Sits between the ALU/result stage and the register-file and display consumers.

---
 rtl/demux32_4_router.sv | 121 ++++++++++++
 1 files changed

// File: rtl/demux32_4_router.sv
// ---------------------------------------------------------------------------
// demux32_4_router
//   1-to-4 router for WIDTH-bit words. One valid/ready input channel is
//   steered by in_sel into one of four independent output FIFOs. Each FIFO
//   has its own valid/ready, so a stalled consumer only blocks traffic
//   bound for its own channel.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : word to route
//   in_sel     : destination channel 0..3
//   in_valid   : in_data/in_sel valid
//   in_ready   : router accepts the word this cycle (combinational)
//   out_data0..3 : registered head-of-FIFO word per channel
//   out_valid  : bit n set when channel n FIFO is non-empty
//   out_ready  : bit n set when consumer n takes its head word
//   occupancy  : entry count per channel, channel n at [n*CW +: CW]
// ---------------------------------------------------------------------------
module demux32_4_router #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [WIDTH-1:0]                  in_data,
   input  logic [1:0]                        in_sel,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [WIDTH-1:0]                  out_data0,
   output logic [WIDTH-1:0]                  out_data1,
   output logic [WIDTH-1:0]                  out_data2,
   output logic [WIDTH-1:0]                  out_data3,
   output logic [3:0]                        out_valid,
   input  logic [3:0]                        out_ready,
   output logic [4*($clog2(DEPTH)+1)-1:0]    occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] r_mem   [4][DEPTH];
   logic [WIDTH-1:0] r_head  [4];
   logic [PW-1:0]    r_rdPtr [4];
   logic [PW-1:0]    r_wrPtr [4];
   logic [CW-1:0]    r_count [4];

   logic [PW-1:0]    w_rdNext [4];
   logic [3:0]       w_push;
   logic [3:0]       w_pop;
   logic             w_inReady;

   // A full channel can still accept when its consumer pops in the same
   // cycle, because the freed slot is exactly the one being written.
   assign w_inReady = rst_n && ((r_count[in_sel] < CW'(DEPTH)) || out_ready[in_sel]);
   assign in_ready  = w_inReady;

   // Per-channel push/pop strobes and the slot that becomes head after a pop.
   always_comb begin
      w_push = '0;
      w_pop  = '0;
      for (int n = 0; n < 4; n++) begin
         w_rdNext[n] = r_rdPtr[n] + 1'b1;
         w_push[n]   = in_valid && w_inReady && (in_sel == 2'(n));
         w_pop[n]    = out_valid[n] && out_ready[n];
      end
   end

   // Outputs are decoded straight from registered state.
   always_comb begin
      occupancy = '0;
      for (int n = 0; n < 4; n++) begin
         out_valid[n]            = (r_count[n] != '0);
         occupancy[n*CW +: CW]   = r_count[n];
      end
   end

   assign out_data0 = r_head[0];
   assign out_data1 = r_head[1];
   assign out_data2 = r_head[2];
   assign out_data3 = r_head[3];

   // FIFO storage, pointers, counts and the registered head word. The head
   // register is loaded with whatever becomes the oldest entry after this
   // cycle's push/pop; when a channel drains it keeps the last popped word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 4; n++) begin
            r_head[n]  <= '0;
            r_rdPtr[n] <= '0;
            r_wrPtr[n] <= '0;
            r_count[n] <= '0;
            for (int d = 0; d < DEPTH; d++) begin
               r_mem[n][d] <= '0;
            end
         end
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (w_push[n]) begin
               r_mem[n][r_wrPtr[n]] <= in_data;
               r_wrPtr[n]           <= r_wrPtr[n] + 1'b1;
            end
            if (w_pop[n]) begin
               r_rdPtr[n] <= w_rdNext[n];
            end
            if (w_push[n] && !w_pop[n]) begin
               r_count[n] <= r_count[n] + 1'b1;
            end else if (!w_push[n] && w_pop[n]) begin
               r_count[n] <= r_count[n] - 1'b1;
            end
            if (w_pop[n] && (r_count[n] >= CW'(2))) begin
               r_head[n] <= r_mem[n][w_rdNext[n]];
            end else if (w_push[n] && ((r_count[n] == '0) ||
                                       (w_pop[n] && (r_count[n] == CW'(1))))) begin
               r_head[n] <= in_data;
            end
         end
      end
   end

endmodule
